// File: rtl/x_burst_feeder_if.sv
// ---------------------------------------------------------------------------
// x_burst_feeder_if
// Bundles the upstream sample handshake and the engine-side signals of the
// burst feeder into one interface.
//   in_valid / in_data / in_ready : upstream 8-bit sample stream
//   eng_ready                     : ready output of the series-sum engine
//   out_x / out_start             : sample and start pulse to the engine
//   busy / fifo_count / ack_err   : status
// Modports:
//   slave  : the feeder itself (consumes samples, drives the engine)
//   master : the environment (upstream source plus engine)
// ---------------------------------------------------------------------------
interface x_burst_feeder_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          eng_ready;
  logic [7:0]    out_x;
  logic          out_start;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          ack_err;

  modport slave (
    input  in_valid, in_data, eng_ready,
    output in_ready, out_x, out_start, busy, fifo_count, ack_err
  );

  modport master (
    output in_valid, in_data, eng_ready,
    input  in_ready, out_x, out_start, busy, fifo_count, ack_err
  );
endinterface

// File: rtl/x_burst_feeder.sv
// ---------------------------------------------------------------------------
// x_burst_feeder
// Buffers 8-bit x samples in a small FIFO and dispatches them to the
// series-sum engine in bursts of BURST samples: a one-cycle start pulse with
// the first sample, then the remaining samples on consecutive cycles. After a
// burst the feeder waits for the engine to drop and then raise eng_ready
// before issuing the next one; if ready never drops within ACK_TIMEOUT cycles
// the sticky ack_err flag is set and the feeder returns to idle.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : x_burst_feeder_if.slave (sample input, engine output, status)
// ---------------------------------------------------------------------------
module x_burst_feeder #(
  parameter int DEPTH       = 8,
  parameter int BURST       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  x_burst_feeder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BURST + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, ACK, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    out_x_q, out_x_d;
  logic          out_start_q, out_start_d;
  logic          busy_q, busy_d;
  logic          ack_err_q, ack_err_d;
  logic          full;
  logic          push;
  logic          pop;

  assign full = (count_q == CW'(DEPTH));
  assign push = bus.in_valid && !full;

  // Next-state logic for the dispatch FSM and the FIFO bookkeeping. The FSM
  // only pops once at least BURST samples are stored, so every pop during
  // STREAM is guaranteed to find data.
  always_comb begin
    state_d     = state_q;
    out_x_d     = out_x_q;
    out_start_d = 1'b0;
    beat_d      = beat_q;
    timer_d     = timer_q;
    ack_err_d   = ack_err_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.eng_ready && (count_q >= CW'(BURST))) begin
          pop         = 1'b1;
          out_x_d     = mem_q[rd_ptr_q];
          out_start_d = 1'b1;
          beat_d      = BW'(1);
          timer_d     = '0;
          state_d     = (BURST == 1) ? ACK : STREAM;
        end
      end
      STREAM: begin
        // eng_ready is deliberately ignored here: a burst always completes.
        pop     = 1'b1;
        out_x_d = mem_q[rd_ptr_q];
        beat_d  = beat_q + BW'(1);
        if ((beat_q + BW'(1)) == BW'(BURST)) begin
          state_d = ACK;
        end
      end
      ACK: begin
        // timer counts cycles already spent in ACK, so the flag lands
        // exactly ACK_TIMEOUT cycles after entry.
        if (!bus.eng_ready) begin
          state_d = DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          ack_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: begin
        if (bus.eng_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sample storage has no reset; stale contents are never read because the
  // count gates every pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_q      <= '0;
      timer_q     <= '0;
      out_x_q     <= '0;
      out_start_q <= 1'b0;
      busy_q      <= 1'b0;
      ack_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_q      <= beat_d;
      timer_q     <= timer_d;
      out_x_q     <= out_x_d;
      out_start_q <= out_start_d;
      busy_q      <= busy_d;
      ack_err_q   <= ack_err_d;
    end
  end

  assign bus.in_ready   = !full;
  assign bus.out_x      = out_x_q;
  assign bus.out_start  = out_start_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count_q;
  assign bus.ack_err    = ack_err_q;
endmodule

// File: tb/tb_x_burst_feeder.sv
// ---------------------------------------------------------------------------
// tb_x_burst_feeder
// Self-checking bench for x_burst_feeder. Inputs are driven on the falling
// edge and outputs are sampled on the falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_x_burst_feeder;
  localparam int DEPTH       = 8;
  localparam int BURST       = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int NSAMP       = 128;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       st;
    logic [7:0] x;
    logic       busy;
    int         cnt;
    logic       rdy;
  } vec_t;

  typedef enum {P_IDLE, P_BURST, P_ACKW, P_LOW, P_RET} phase_e;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  vec_t       vecs [13];
  logic [7:0] fill [8];
  logic [7:0] sb [$];

  x_burst_feeder_if #(.DEPTH(DEPTH)) bus ();

  x_burst_feeder #(
    .DEPTH(DEPTH),
    .BURST(BURST),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs and returns at the following falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.eng_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_out_start"}, bus.out_start, 0);
    checkOutput({tag, "_out_x"}, bus.out_x, 0);
    checkOutput({tag, "_count"}, bus.fifo_count, 0);
    checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_ack_err"}, bus.ack_err, 0);
  endtask

  task automatic checkBeat(input string tag, input logic st, input logic [7:0] x);
    checkOutput({tag, "_start"}, bus.out_start, st);
    checkOutput({tag, "_x"}, bus.out_x, x);
  endtask

  // Engine acknowledge: ready low for one cycle, then high again.
  task automatic ackEngine(input string tag);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput({tag, "_busy_after_ack"}, bus.busy, 0);
  endtask

  initial begin
    phase_e     phase;
    int         pushed, observed, mc, beats, wait_cnt, ack_delay, low_left, cyc;
    logic       expect_start, v, rdy;
    logic [7:0] d, ev;

    vecs[0]  = '{1'b1, 8'h06, 1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b1};
    vecs[1]  = '{1'b1, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 2, 1'b1};
    vecs[2]  = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 3, 1'b1};
    vecs[3]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 3, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h0F, 1'b1, 2, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 1, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.eng_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    // Basic burst of 06,0F,01,00 followed by an acknowledge.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].r);
      checkOutput($sformatf("vec%0d_start", i), bus.out_start, vecs[i].st);
      checkOutput($sformatf("vec%0d_x", i), bus.out_x, vecs[i].x);
      checkOutput($sformatf("vec%0d_busy", i), bus.busy, vecs[i].busy);
      checkOutput($sformatf("vec%0d_count", i), bus.fifo_count, vecs[i].cnt);
      checkOutput($sformatf("vec%0d_in_ready", i), bus.in_ready, vecs[i].rdy);
    end

    // Three samples do not start a burst; the fourth does one cycle later.
    applyStimulus(1'b1, 8'h11, 1'b1);
    applyStimulus(1'b1, 8'h22, 1'b1);
    applyStimulus(1'b1, 8'h33, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("three_count", bus.fifo_count, 3);
      checkOutput("three_nostart", bus.out_start, 0);
    end
    applyStimulus(1'b1, 8'h44, 1'b1);
    checkOutput("four_count", bus.fifo_count, 4);
    checkOutput("four_nostart", bus.out_start, 0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkBeat("four_b0", 1'b1, 8'h11);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkBeat("four_b1", 1'b0, 8'h22);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkBeat("four_b2", 1'b0, 8'h33);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkBeat("four_b3", 1'b0, 8'h44);
    checkOutput("four_drained", bus.fifo_count, 0);
    ackEngine("four");

    // Fill the FIFO with the engine not ready; a ninth push is refused.
    for (int i = 0; i < 8; i++) begin
      fill[i] = 8'hA0 + 8'(i);
      applyStimulus(1'b1, fill[i], 1'b0);
    end
    checkOutput("full_count", bus.fifo_count, 8);
    checkOutput("full_in_ready", bus.in_ready, 0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("full_refused", bus.fifo_count, 8);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkBeat($sformatf("full_a%0d", i), i == 0, fill[i]);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("full_wait_ack", bus.out_start, 0);
      checkOutput("full_wait_count", bus.fifo_count, 4);
    end
    ackEngine("full1");
    checkOutput("full_no_early_start", bus.out_start, 0);
    for (int i = 4; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkBeat($sformatf("full_a%0d", i), i == 4, fill[i]);
    end
    ackEngine("full2");

    // Acknowledge timeout: ready held high after the burst.
    for (int i = 0; i < 8; i++) begin
      fill[i] = 8'hB0 + 8'(i);
      applyStimulus(1'b1, fill[i], 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkBeat($sformatf("to_b%0d", i), i == 0, fill[i]);
    end
    for (int k = 1; k <= ACK_TIMEOUT; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (k < ACK_TIMEOUT) begin
        checkOutput($sformatf("to_noerr_k%0d", k), bus.ack_err, 0);
      end else begin
        checkOutput("to_err_set", bus.ack_err, 1);
        checkOutput("to_idle_busy", bus.busy, 0);
      end
    end
    for (int i = 4; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkBeat($sformatf("to_b%0d", i), i == 4, fill[i]);
    end
    ackEngine("to");
    checkOutput("to_err_sticky", bus.ack_err, 1);

    // Reset during the second beat of a burst takes effect immediately.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkBeat("rst_b0", 1'b1, 8'hC0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkBeat("rst_b1", 1'b0, 8'hC1);
    #2;
    rst = 1'b1;
    #1;
    checkReset("midrst");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("postrst_nostart", bus.out_start, 0);
    checkOutput("postrst_count", bus.fifo_count, 0);

    // Randomized traffic against a transaction-level engine model and
    // a sample scoreboard; the first 64 samples arrive back to back.
    phase        = P_IDLE;
    pushed       = 0;
    observed     = 0;
    beats        = 0;
    wait_cnt     = 0;
    ack_delay    = 5;
    low_left     = 0;
    cyc          = 0;
    expect_start = 1'b0;
    while ((pushed < NSAMP || phase != P_IDLE || (pushed - observed) >= BURST) && cyc < 4000) begin
      if (phase == P_RET) phase = P_IDLE;
      if (expect_start) begin
        checkOutput("rnd_start", bus.out_start, 1);
        phase = P_BURST;
        beats = 0;
      end else begin
        checkOutput("rnd_nostart", bus.out_start, 0);
      end
      if (phase == P_BURST) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rnd_underflow actual=sample required=none");
        end else begin
          ev = sb.pop_front();
          checkOutput("rnd_data", bus.out_x, ev);
        end
        observed++;
        beats++;
        if (beats == BURST) begin
          phase     = P_ACKW;
          wait_cnt  = 0;
          ack_delay = (pushed <= 64) ? 5 : int'($urandom_range(0, 10));
        end
      end
      mc = pushed - observed;
      checkOutput("rnd_count", bus.fifo_count, mc);
      checkOutput("rnd_in_ready", bus.in_ready, mc < DEPTH);
      checkOutput("rnd_busy", bus.busy, phase != P_IDLE);

      case (phase)
        P_IDLE:  rdy = ($urandom_range(0, 3) != 0);
        P_ACKW: begin
          if (wait_cnt >= ack_delay) begin
            rdy      = 1'b0;
            phase    = P_LOW;
            low_left = $urandom_range(1, 3);
          end else begin
            rdy = 1'b1;
            wait_cnt++;
          end
        end
        P_LOW: begin
          low_left--;
          if (low_left == 0) begin
            rdy   = 1'b1;
            phase = P_RET;
          end else begin
            rdy = 1'b0;
          end
        end
        default: rdy = 1'b1;
      endcase

      if (pushed < NSAMP) v = (pushed < 64) ? 1'b1 : ($urandom_range(0, 1) == 1);
      else v = 1'b0;
      d = 8'($urandom_range(0, 255));
      if (v && mc < DEPTH) begin
        sb.push_back(d);
        pushed++;
      end
      expect_start = (phase == P_IDLE) && rdy && (mc >= BURST);
      applyStimulus(v, d, rdy);
      cyc++;
    end
    if (cyc >= 4000) begin
      checks++;
      errors++;
      $display("[TB] FAIL rnd_timeout actual=%0d required=<4000 cycles", cyc);
    end
    checkOutput("rnd_delivered", observed, NSAMP);
    checkOutput("rnd_ack_err", bus.ack_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/x_burst_feeder.md
Name: x_burst_feeder

Overview:
- Upstream stage of the series-sum engine (the `top` core).
- Buffers a stream of 8-bit x samples arriving on a valid/ready interface in a small FIFO.
- Dispatches the samples to the engine as bursts: a one-cycle start pulse carrying the first sample, then BURST-1 further samples on consecutive cycles.
- Each burst waits for the engine's ready, and the engine must acknowledge each burst before the next one is issued.

Parameters:
- DEPTH, 8: FIFO depth in samples; power of two, >= BURST.
- BURST, 4: samples per engine job; the first sample rides the start pulse.
- ACK_TIMEOUT, 16: cycles to wait for eng_ready to drop after a burst before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_data  in  8  upstream sample.
- in_ready  out  1  FIFO can accept; equals !full.
- eng_ready  in  1  engine ready (the engine's ready output).
- out_x  out  8  sample to engine (drives in_x_input).
- out_start  out  1  one-cycle start pulse to engine.
- busy  out  1  burst in flight or awaiting acknowledge.
- fifo_count  out  clog2(DEPTH)+1  samples currently stored.
- ack_err  out  1  sticky: engine never dropped ready after a burst.

Behaviour:
- Reset (async, immediate): FIFO empties; fifo_count=0; in_ready=1; out_x=0; out_start=0; busy=0; ack_err=0; state=IDLE.
- All outputs are registered except in_ready, which is derived combinationally from the registered count.

FIFO:
- Push when in_valid && in_ready.
- Pop only under FSM control.
- Simultaneous push and pop: allowed when full (pop frees the slot in the same cycle? no, in_ready=!full, so push is refused when full) and when empty-with-push (the pop is never issued because the FSM requires count>=BURST).
- Pointers wrap modulo DEPTH; count is exact under concurrent push/pop.

FSM:
- IDLE: busy=0. When eng_ready==1 and fifo_count>=BURST:
  - pop the head;
  - out_x<=head; out_start<=1;
  - beat counter<=1; go to STREAM.
  - If either condition is unmet, stay in IDLE; out_x holds its last value.
- STREAM: out_start<=0. Each cycle:
  - pop the head; out_x<=head; beat++.
  - When beat reaches BURST, with the last sample now driven, go to ACK.
  - BURST samples appear on out_x on BURST consecutive cycles; the first coincides with out_start=1.
- ACK: busy=1. Wait for eng_ready==0.
  - On eng_ready==0, go to DONE.
  - If ACK_TIMEOUT cycles elapse with eng_ready still 1, set ack_err (sticky until rst) and go to IDLE.
- DONE: wait for eng_ready==1, then go to IDLE.
  - The next start can issue at the earliest one cycle after ready returns.
- BURST==1: skip STREAM and go IDLE -> ACK directly.

Latency and timing:
- Sample-to-start latency: the start is issued in the first cycle where the state is IDLE, eng_ready=1, and the registered fifo_count>=BURST.
- A push in cycle t is counted from cycle t+1.

Boundary and mid-operation rules:
- eng_ready dropping during STREAM: ignored; the burst always completes, and the engine is required to accept the full burst.
- Upstream keeps pushing during a burst: allowed while not full; pops guarantee a free slot each STREAM cycle.
- rst mid-burst: the burst is abandoned; queued samples are lost; outputs return to their reset values.

Test Plan:
- Push 06,0F,01,00 with eng_ready=1 -> out_start=1 with out_x=06, then out_x=0F,01,00 on the next 3 cycles; fifo_count returns to 0; busy=1 until eng_ready low-then-high.
- Push 3 samples only -> no out_start, fifo_count=3; push a 4th -> burst starts the cycle after count reaches 4.
- Fill 8 samples with eng_ready=0 -> in_ready=0 at count 8, and a 9th push is refused. Raise eng_ready -> burst of the first 4 in order, then the second burst only after an ack low/high cycle.
- Hold eng_ready=1 permanently after a burst -> ack_err=1 exactly 16 cycles after entering ACK; state returns to IDLE; the next burst issues normally; ack_err stays 1.
- Assert rst during the 2nd STREAM beat -> out_start=0, out_x=0, fifo_count=0, in_ready=1 immediately (asynchronously).
- Continuous back-to-back push at 1 sample/cycle with an engine acking after 5 cycles -> no sample lost or reordered, checked against a scoreboard over 64 samples.
